// File: rtl/counter16_down_timer.sv
// counter16_down_timer: loadable down-counter with one-shot and periodic terminal-count modes
module counter16_down_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clock0,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             periodic,
   input  logic             ack,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             expired
);
   typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   // next state: load beats ack, ack beats the decrement
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (load) begin
         count_d  = load_value;
         reload_d = load_value;
         state_d  = (load_value != '0) ? RUN : IDLE;
      end else if (ack && state_q == EXPIRED) begin
         state_d = IDLE;
      end else if (state_q == RUN && enable) begin
         if (count_q == WIDTH'(1)) begin
            tc_d    = 1'b1;
            count_d = periodic ? reload_q : '0;
            state_d = periodic ? RUN : EXPIRED;
         end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end
   // state and output registers, cleared asynchronously
   always_ff @(posedge clock0 or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end
   assign count   = count_q;
   assign tc      = tc_q;
   assign busy    = (state_q == RUN);
   assign expired = (state_q == EXPIRED);
endmodule

// File: tb/tb_counter16_down_timer.sv
// tb_counter16_down_timer: randomized and directed checks against a behavioural timer model
module tb_counter16_down_timer;
   logic        clock0 = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_value = '0;
   logic        enable = 1'b0;
   logic        periodic = 1'b0;
   logic        ack = 1'b0;
   logic [15:0] count;
   logic        tc, busy, expired;
   int total = 0;
   int bad = 0;
   int m_cnt, m_rel, m_mode;
   bit m_tc;
   int tc_seen;

   counter16_down_timer #(.WIDTH(16)) dut (
      .clock0(clock0), .reset(reset), .load(load), .load_value(load_value),
      .enable(enable), .periodic(periodic), .ack(ack),
      .count(count), .tc(tc), .busy(busy), .expired(expired)
   );

   always #5 clock0 = ~clock0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_rel = 0;
      m_mode = 0;
      m_tc = 0;
   endtask

   // mode: 0 idle, 1 counting, 2 expired
   task automatic model_edge();
      m_tc = 0;
      if (load) begin
         m_cnt = load_value;
         m_rel = load_value;
         m_mode = (load_value == 0) ? 0 : 1;
      end else if (ack && m_mode == 2) begin
         m_mode = 0;
      end else if (m_mode == 1 && enable) begin
         if (m_cnt == 1) begin
            m_tc = 1;
            m_cnt = periodic ? m_rel : 0;
            m_mode = periodic ? 1 : 2;
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
   endtask

   task automatic compare_all();
      check("count", count, m_cnt);
      check("tc", tc, m_tc);
      check("busy", busy, m_mode == 1);
      check("expired", expired, m_mode == 2);
   endtask

   task automatic tick();
      @(posedge clock0);
      model_edge();
      #1;
      compare_all();
      if (tc) tc_seen++;
   endtask

   task automatic set_in(input bit l, input int lv, input bit en, input bit per, input bit a);
      load = l;
      load_value = lv[15:0];
      enable = en;
      periodic = per;
      ack = a;
   endtask

   initial begin
      int exp_os[6];
      int exp_gate[6];
      bit gate_en[6];
      exp_os = '{4, 3, 2, 1, 0, 0};
      exp_gate = '{3, 3, 3, 2, 1, 0};
      gate_en = '{1, 0, 0, 1, 1, 1};
      model_reset();
      @(negedge clock0);
      @(negedge clock0);
      compare_all();
      reset = 1'b1;
      // reset mid-run
      set_in(1, 100, 1, 0, 0);
      tick();
      set_in(0, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) tick();
      check("run_cnt", count, 90);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("arst_count", count, 0);
      check("arst_busy", busy, 0);
      check("arst_tc", tc, 0);
      check("arst_exp", expired, 0);
      @(negedge clock0);
      reset = 1'b1;
      // one-shot
      set_in(1, 5, 1, 0, 0);
      tick();
      check("os_load", count, 5);
      set_in(0, 0, 1, 0, 0);
      tc_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("os_seq", count, exp_os[i]);
      end
      check("os_tcs", tc_seen, 1);
      check("os_exp", expired, 1);
      set_in(0, 0, 1, 0, 1);
      tick();
      check("os_ack", expired, 0);
      // periodic
      set_in(1, 3, 1, 1, 0);
      tick();
      set_in(0, 0, 1, 1, 0);
      tc_seen = 0;
      for (int i = 0; i < 12; i++) tick();
      check("per_tcs", tc_seen, 4);
      check("per_busy", busy, 1);
      set_in(1, 1, 1, 1, 0);
      tick();
      set_in(0, 0, 1, 1, 0);
      tc_seen = 0;
      for (int i = 0; i < 8; i++) tick();
      check("per1_tcs", tc_seen, 8);
      // enable gating
      set_in(1, 4, 1, 0, 0);
      tick();
      tc_seen = 0;
      for (int i = 0; i < 6; i++) begin
         set_in(0, 0, gate_en[i], 0, 0);
         tick();
         check("gate_seq", count, exp_gate[i]);
         check("gate_tc", tc, i == 5);
      end
      // load on a periodic terminal edge
      set_in(1, 2, 1, 1, 0);
      tick();
      set_in(0, 0, 1, 1, 0);
      tick();
      set_in(1, 7, 1, 1, 0);
      tick();
      check("ld_tc_cnt", count, 7);
      check("ld_tc_sup", tc, 0);
      set_in(1, 0, 1, 1, 0);
      tick();
      check("ld0_busy", busy, 0);
      // ack and load together in EXPIRED
      set_in(1, 1, 1, 0, 0);
      tick();
      set_in(0, 0, 1, 0, 0);
      tick();
      check("pre_exp", expired, 1);
      set_in(1, 9, 1, 0, 1);
      tick();
      check("ldack_busy", busy, 1);
      check("ldack_cnt", count, 9);
      // full range one-shot
      set_in(1, 16'hFFFF, 1, 0, 0);
      tick();
      set_in(0, 0, 1, 0, 0);
      tc_seen = 0;
      for (int i = 0; i < 65534; i++) tick();
      check("full_notc", tc_seen, 0);
      tick();
      check("full_tc", tc, 1);
      for (int i = 0; i < 5; i++) tick();
      check("full_hold", count, 0);
      check("full_tcs", tc_seen, 1);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] lv;
         lv = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
         set_in($urandom_range(0, 15) == 0, lv, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1), $urandom_range(0, 7) == 0);
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
